psram_ctrl_emu: RTL and testbench
=================================

Name: psram_ctrl_emu

Overview:
- Cycle-approximate responder for the PSRAM controller user interface: read/write/byte_write/addr/din in, dout/busy out.
- Backed by on-chip block RAM instead of external PSRAM.
- Lets memory test tops and other initiators run in simulation and on-board bring-up without the PsramController or PSRAM pins.
- Emulates init delay and 1x/2x variable-latency transaction lengths so initiator latency counters and timeouts get exercised.

Parameters:
LATENCY, 4, emulated PSRAM latency count; scales transaction length
DEPTH_BITS, 12, log2 of 16-bit words stored; address bits above DEPTH_BITS+1 ignored (aliasing)
INIT_CYCLES, 64, busy-high cycles after reset before first command accepted
DOUBLE_LAT_MODE, 2, 0 = always 1x, 1 = always 2x, 2 = pseudo-random per command
LFSR_SEED, 8'hA5, reset value of latency LFSR (must be nonzero)

Ports:
clk  input  1  single clock, all logic on rising edge
resetn  input  1  reset; synchronous and active-low
read  input  1  one-cycle read request pulse
write  input  1  one-cycle write request pulse
byte_write  input  1  qualifies write: 1 = single byte, 0 = full 16-bit word
addr  input  22  byte address; word index addr[DEPTH_BITS:1], byte lane addr[0]
din  input  16  write data
dout  output  16  read data word
busy  output  1  high during init and while a command is in flight
lat_2x  output  1  last accepted command used 2x latency
proto_err  output  1  sticky protocol-violation flag (see Optional Feature)

Behaviour:
- Reset (resetn=0 at a clk edge): busy=1, dout=0, lat_2x=0, proto_err=0, LFSR=LFSR_SEED, init counter cleared, state=INIT. RAM contents not cleared.
- States: INIT -> IDLE -> WAIT -> DONE -> IDLE.
- INIT: busy=1 for exactly INIT_CYCLES cycles after the first cycle with resetn=1, then go to IDLE with busy=0.
- IDLE, accept:
  - A command is accepted when busy=0 and (read or write)=1.
  - busy goes high on the next cycle.
  - addr, din and byte_write are latched at accept.
- IDLE, simultaneous read and write: write wins; read is dropped.
- WAIT, latency choice:
  - k=1 or 2, chosen at accept.
  - Mode 2 uses LFSR[0], with k=2 when LFSR[0]=1.
  - LFSR is 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advanced once per accepted command after sampling.
  - lat_2x=(k==2), updated at accept.
- WAIT, busy length: busy stays high for N cycles, N = 2+LATENCY*k for writes and 6+LATENCY*k for reads. LATENCY=4 gives 6/10 for writes and 10/14 for reads.
- Write commit:
  - The RAM write occurs in the last busy cycle.
  - Word write (byte_write=0): stores din.
  - Byte write: stores only lane addr[0]. Lane 0 <= din[7:0]; lane 1 <= din[15:8]. Other lane is unchanged.
- Read return:
  - dout is updated with the full word at the latched address in the last busy cycle, so it is valid in the first cycle busy=0.
  - dout holds until the next read completes. Writes never change dout.
- DONE: busy=0; return to IDLE in the same cycle. Back-to-back commands are allowed: a new request may be accepted in the first busy=0 cycle.
- Request while busy: ignored; no state change.
- Address aliasing: addr bits above DEPTH_BITS+1 are ignored; addresses alias modulo 2^(DEPTH_BITS+1) bytes.
- Reset mid-operation: the in-flight command is aborted with no RAM write and dout=0, and the block re-enters INIT.
- RAM: single-port inferred BSRAM, 2^DEPTH_BITS x 16, synchronous read pipelined within the WAIT window. No combinational path from addr to dout.

Optional Feature:
- Macro PSRAM_EMU_PROTO_CHECK_EN.
- Defined: proto_err sets and stays 1 until reset on any of:
  - read or write high while busy=1;
  - read and write high together;
  - read or write high for 2+ consecutive cycles.
- Undefined: proto_err is tied to 0 and the check logic is not built. The port is still present.

Test Plan:
- Init: release resetn, INIT_CYCLES=64 -> busy=1 for exactly 64 cycles, then 0; dout=0, lat_2x=0.
- Word write/read:
  - Mode 0, LATENCY=4: write addr=0x000010, din=0xBEEF -> busy high 6 cycles.
  - Then read 0x000010 -> busy high 10 cycles; dout=0xBEEF in first busy=0 cycle.
- Byte lanes: word 0x1234 at addr 0x20, then byte_write addr=0x21 din=0xABAB -> read 0x20 returns 0xAB34; byte_write addr=0x20 din=0x5656 -> 0xAB56.
- 2x latency:
  - Mode 1: read -> busy high 14 cycles, lat_2x=1.
  - Mode 2, seed 0xA5: the 1x/2x sequence over 16 commands matches the reference LFSR model.
- Boundary:
  - Write 0x1111 to addr 0, then 0x2222 to addr 2^(DEPTH_BITS+1) -> read addr 0 returns 0x2222 (alias).
  - Read and write same cycle -> only the write executes.
- Reset mid-op plus checker: resetn low for 1 cycle during a write's WAIT -> RAM at that address unchanged, busy=1 for 64 cycles. With PSRAM_EMU_PROTO_CHECK_EN, a read pulse while busy -> proto_err=1 until reset.

Source files
------------

// File: rtl/psram_ctrl_emu.sv
// psram_ctrl_emu: block-RAM stand-in for the PSRAM controller user port.
// Mimics the init delay and the 1x/2x variable-latency busy windows of a
// real PSRAM controller so initiator latency counters and timeouts are
// exercised without the external device.
// Optional build macro: PSRAM_EMU_PROTO_CHECK_EN (sticky protocol checker
// driving proto_err; without it proto_err is tied low).
//
// state  | meaning
// -------+---------------------------------------------------------------
// INIT   | post-reset delay, busy=1 for INIT_CYCLES cycles
// IDLE   | busy=0, accepts read/write (also serves as the DONE cycle that
//        | follows WAIT, so back-to-back commands are accepted there)
// WAIT   | command in flight, busy=1; RAM write / dout load on last cycle
module psram_ctrl_emu #(
    parameter int         LATENCY         = 4,
    parameter int         DEPTH_BITS      = 12,
    parameter int         INIT_CYCLES     = 64,
    parameter int         DOUBLE_LAT_MODE = 2,
    parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        read,
    input  logic        write,
    input  logic        byte_write,
    input  logic [21:0] addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        busy,
    output logic        lat_2x,
    output logic        proto_err
);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam int MAX_N = (INIT_CYCLES > 6 + 2 * LATENCY) ? INIT_CYCLES : 6 + 2 * LATENCY;
    localparam int CW    = $clog2(MAX_N + 1);

    // busy lengths minus one, loaded into the down-counter at accept
    localparam logic [CW-1:0] WR1_M1 = CW'(2 + LATENCY - 1);
    localparam logic [CW-1:0] WR2_M1 = CW'(2 + 2 * LATENCY - 1);
    localparam logic [CW-1:0] RD1_M1 = CW'(6 + LATENCY - 1);
    localparam logic [CW-1:0] RD2_M1 = CW'(6 + 2 * LATENCY - 1);
    localparam logic [CW-1:0] INIT_M1 = CW'(INIT_CYCLES - 1);

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [7:0]            lfsr;
    logic [7:0]            lfsr_next;
    logic                  k2;
    logic [CW-1:0]         len_m1;
    logic                  is_wr_q;
    logic                  bw_q;
    logic                  lane_q;
    logic [DEPTH_BITS-1:0] idx_q;
    logic [15:0]           din_q;
    logic [15:0]           rd_q;
    logic                  ram_we;
    logic                  unused_addr;

    logic [15:0] mem [2**DEPTH_BITS];

    // upper address bits alias by design
    assign unused_addr = ^addr[21:DEPTH_BITS+1];

    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // latency multiplier choice and resulting busy length for the request on the port
    always_comb begin
        k2 = 1'b0;
        if (DOUBLE_LAT_MODE == 1) begin
            k2 = 1'b1;
        end else if (DOUBLE_LAT_MODE == 2) begin
            k2 = lfsr[0];
        end
        if (write) begin
            len_m1 = k2 ? WR2_M1 : WR1_M1;
        end else begin
            len_m1 = k2 ? RD2_M1 : RD1_M1;
        end
    end

    // gated by resetn so a reset landing on the final WAIT cycle aborts the write
    assign ram_we = resetn && (state == S_WAIT) && (cnt == '0) && is_wr_q;

    // single-port RAM: byte-lane write on commit, registered read every cycle
    always_ff @(posedge clk) begin
        if (ram_we) begin
            if (!bw_q || !lane_q) begin
                mem[idx_q][7:0] <= din_q[7:0];
            end
            if (!bw_q || lane_q) begin
                mem[idx_q][15:8] <= din_q[15:8];
            end
        end
        rd_q <= mem[idx_q];
    end

    // sequencing FSM with shared down-counter for init delay and busy window
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= S_INIT;
            busy   <= 1'b1;
            cnt    <= INIT_M1;
            dout   <= '0;
            lat_2x <= 1'b0;
            lfsr   <= LFSR_SEED;
        end else begin
            case (state)
                S_INIT: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (read || write) begin
                        state   <= S_WAIT;
                        busy    <= 1'b1;
                        cnt     <= len_m1;
                        is_wr_q <= write;
                        bw_q    <= byte_write;
                        lane_q  <= addr[0];
                        idx_q   <= addr[DEPTH_BITS:1];
                        din_q   <= din;
                        lat_2x  <= k2;
                        lfsr    <= lfsr_next;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        if (!is_wr_q) begin
                            dout <= rd_q;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_INIT;
                    busy  <= 1'b1;
                    cnt   <= INIT_M1;
                end
            endcase
        end
    end

`ifdef PSRAM_EMU_PROTO_CHECK_EN
    logic prev_rd;
    logic prev_wr;
    logic pe_q;

    // sticky flag: request while busy, read+write together, or held request
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_rd <= 1'b0;
            prev_wr <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            prev_rd <= read;
            prev_wr <= write;
            if (((read || write) && busy) || (read && write) ||
                (read && prev_rd) || (write && prev_wr)) begin
                pe_q <= 1'b1;
            end
        end
    end

    assign proto_err = pe_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_psram_ctrl_emu.sv
// Directed bench for psram_ctrl_emu (LATENCY=4, DEPTH_BITS=12,
// INIT_CYCLES=64, pseudo-random latency mode, seed 0xA5).
// Latency multiplier per command after reset, worked out by hand from the
// x^8+x^6+x^5+x^4+1 LFSR starting at 0xA5 (LFSR[0] sampled at accept):
//   cmd : 0 1 2 3 4 5 6 7 8 9 10 11 12 13 14 15
//   k   : 2 1 2 1 1 2 2 2 1 2 2  2  1  2  2  1
// Busy lengths: write 2+4k (6/10), read 6+4k (10/14).
module tb_psram_ctrl_emu;

    logic        clk = 1'b0;
    logic        resetn;
    logic        read;
    logic        write;
    logic        byte_write;
    logic [21:0] addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        busy;
    logic        lat_2x;
    logic        proto_err;

    int total = 0;
    int bad   = 0;

`ifdef PSRAM_EMU_PROTO_CHECK_EN
    localparam logic PE_ON = 1'b1;
`else
    localparam logic PE_ON = 1'b0;
`endif

    psram_ctrl_emu #(
        .LATENCY(4),
        .DEPTH_BITS(12),
        .INIT_CYCLES(64),
        .DOUBLE_LAT_MODE(2),
        .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .read(read),
        .write(write),
        .byte_write(byte_write),
        .addr(addr),
        .din(din),
        .dout(dout),
        .busy(busy),
        .lat_2x(lat_2x),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // hold reset for 'hold' rising edges, check reset outputs, count init busy
    task automatic do_reset(input string tag, input int hold);
        int n;
        resetn = 1'b0;
        read = 1'b0;
        write = 1'b0;
        byte_write = 1'b0;
        for (int i = 0; i < hold; i++) @(negedge clk);
        check({tag, "_rst_busy"}, 32'(busy), 32'd1);
        check({tag, "_rst_dout"}, 32'(dout), 32'h0);
        check({tag, "_rst_lat"}, 32'(lat_2x), 32'd0);
        check({tag, "_rst_pe"}, 32'(proto_err), 32'd0);
        resetn = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 500) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_init_len"}, 32'(n), 32'd64);
    endtask

    // issue one command at the current falling edge; optionally poke a read
    // while busy on busy cycle 'poke'; returns in the first busy=0 cycle
    task automatic cmd(input string tag, input logic rd, input logic wr, input logic bw,
                       input logic [21:0] a, input logic [15:0] d, input int exp_len,
                       input logic exp_lat, input logic [15:0] exp_dout, input int poke);
        int n;
        read = rd;
        write = wr;
        byte_write = bw;
        addr = a;
        din = d;
        @(negedge clk);
        read = 1'b0;
        write = 1'b0;
        byte_write = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            read = (n == poke);
            @(negedge clk);
        end
        read = 1'b0;
        check({tag, "_len"}, 32'(n), 32'(exp_len));
        check({tag, "_lat"}, 32'(lat_2x), 32'(exp_lat));
        check({tag, "_dout"}, 32'(dout), 32'(exp_dout));
    endtask

    initial begin
        resetn = 1'b0;
        read = 1'b0;
        write = 1'b0;
        byte_write = 1'b0;
        addr = '0;
        din = '0;

        do_reset("init", 2);

        // word write / read
        cmd("c0_wr10",   0, 1, 0, 22'h000010, 16'hBEEF, 10, 1, 16'h0000, 0);
        cmd("c1_rd10",   1, 0, 0, 22'h000010, 16'h0000, 10, 0, 16'hBEEF, 0);
        // byte lanes
        cmd("c2_wr20",   0, 1, 0, 22'h000020, 16'h1234, 10, 1, 16'hBEEF, 0);
        cmd("c3_bw21",   0, 1, 1, 22'h000021, 16'hABAB,  6, 0, 16'hBEEF, 0);
        cmd("c4_rd20",   1, 0, 0, 22'h000020, 16'h0000, 10, 0, 16'hAB34, 0);
        cmd("c5_bw20",   0, 1, 1, 22'h000020, 16'h5656, 10, 1, 16'hAB34, 0);
        cmd("c6_rd20",   1, 0, 0, 22'h000020, 16'h0000, 14, 1, 16'hAB56, 0);
        // aliasing: 0x2000 maps onto word 0
        cmd("c7_wr0",    0, 1, 0, 22'h000000, 16'h1111, 10, 1, 16'hAB56, 0);
        cmd("c8_wralias",0, 1, 0, 22'h002000, 16'h2222,  6, 0, 16'hAB56, 0);
        cmd("c9_rd0",    1, 0, 0, 22'h000000, 16'h0000, 14, 1, 16'h2222, 0);
        check("pe_clean", 32'(proto_err), 32'd0);
        // read and write together: write wins, dout untouched
        cmd("c10_rw",    1, 1, 0, 22'h000040, 16'h7777, 10, 1, 16'h2222, 0);
        cmd("c11_rd40",  1, 0, 0, 22'h000040, 16'h0000, 14, 1, 16'h7777, 0);
        cmd("c12_rd10",  1, 0, 0, 22'h000010, 16'h0000, 10, 0, 16'hBEEF, 0);
        // read poked while busy must be ignored (length and LFSR unaffected)
        cmd("c13_wrpoke",0, 1, 0, 22'h000010, 16'hCAFE, 10, 1, 16'hBEEF, 3);
        check("pe_flag", 32'(proto_err), 32'(PE_ON));
        cmd("c14_rd10",  1, 0, 0, 22'h000010, 16'h0000, 14, 1, 16'hCAFE, 0);
        cmd("c15_rd20",  1, 0, 0, 22'h000020, 16'h0000, 10, 0, 16'hAB56, 0);
        check("pe_sticky", 32'(proto_err), 32'(PE_ON));

        // reset during a write's WAIT window aborts the write
        write = 1'b1;
        addr = 22'h000020;
        din = 16'hFFFF;
        @(negedge clk);
        write = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        do_reset("midop", 1);
        cmd("r0_rd20",   1, 0, 0, 22'h000020, 16'h0000, 14, 1, 16'hAB56, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
